// File: rtl/zero_pattern_pkg.sv
// Shared constants, state type and pattern helpers for zero_pattern_gen.
// Exports DATA_W, ZCNT_W, IDX_W, state_e, min_pat(), max_pat().
package zero_pattern_pkg;

  localparam int DATA_W = 8;
  localparam int ZCNT_W = 4;
  localparam int IDX_W  = 7;

  typedef enum logic {
    IDLE,
    EMIT
  } state_e;

  // Smallest byte with k zeros: ones packed into the LSBs.
  function automatic logic [DATA_W-1:0] min_pat(
    input logic [ZCNT_W-1:0] k
  );
    logic [DATA_W:0] t;
    t = (9'd1 << (4'd8 - k)) - 9'd1;
    return t[DATA_W-1:0];
  endfunction

  // Largest byte with k zeros: ones packed into the MSBs.
  function automatic logic [DATA_W-1:0] max_pat(
    input logic [ZCNT_W-1:0] k
  );
    logic [DATA_W:0] t;
    t = (9'd1 << k) - 9'd1;
    return ~t[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/zero_pattern_gen_next.sv
// Combinational successor: next larger byte with the same popcount.
// Ports: x_i (current byte), next_o (successor, truncated to 8 bits).
module next_same_weight
  import zero_pattern_pkg::*;
(
  input  logic [DATA_W-1:0] x_i,
  output logic [DATA_W-1:0] next_o
);

  logic [DATA_W:0] x9;
  logic [DATA_W:0] c;
  logic [DATA_W:0] r;
  logic [DATA_W:0] s;
  logic [3:0]      tz;

  always_comb begin
    x9 = {1'b0, x_i};
    // c isolates the lowest set bit, so it is one-hot or zero.
    c  = x9 & (~x9 + 9'd1);
    r  = x9 + c;
    tz = 4'd0;
    unique case (1'b1)
      c[0]:    tz = 4'd0;
      c[1]:    tz = 4'd1;
      c[2]:    tz = 4'd2;
      c[3]:    tz = 4'd3;
      c[4]:    tz = 4'd4;
      c[5]:    tz = 4'd5;
      c[6]:    tz = 4'd6;
      c[7]:    tz = 4'd7;
      c[8]:    tz = 4'd8;
      default: tz = 4'd0;
    endcase
    // Shift replaces the divide by c in the classic formulation.
    s      = ((x9 ^ r) >> 2) >> tz;
    next_o = r[DATA_W-1:0] | s[DATA_W-1:0];
  end

endmodule

// File: rtl/zero_pattern_gen.sv
// Enumerates all bytes with exactly k zero bits in ascending order.
// Ports: clk, reset, start, zeros, ready in; busy, valid, data, last, index, err out.
module zero_pattern_gen
  import zero_pattern_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ZCNT_W-1:0] zeros,
  output logic              busy,
  output logic              valid,
  input  logic              ready,
  output logic [DATA_W-1:0] data,
  output logic              last,
  output logic [IDX_W-1:0]  index,
  output logic              err
);

  state_e            state_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;
  logic [DATA_W-1:0] maxp_q;
  logic [IDX_W-1:0]  idx_q;
  logic              last_q;
  logic              busy_q;
  logic              valid_q;
  logic              err_q;
  logic              bad_k;

  next_same_weight u_next (
    .x_i    (data_q),
    .next_o (data_d)
  );

  assign bad_k = zeros > 4'd8;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      maxp_q  <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && bad_k) begin
            err_q <= 1'b1;
          end else if (start) begin
            state_q <= EMIT;
            data_q  <= min_pat(zeros);
            maxp_q  <= max_pat(zeros);
            // k=0 and k=8 have a single pattern.
            last_q  <= min_pat(zeros) == max_pat(zeros);
            idx_q   <= '0;
            busy_q  <= 1'b1;
            valid_q <= 1'b1;
          end
        end
        EMIT: begin
          if (ready && last_q) begin
            state_q <= IDLE;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
          end else if (ready) begin
            data_q <= data_d;
            idx_q  <= idx_q + 7'd1;
            last_q <= data_d == maxp_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy  = busy_q;
  assign valid = valid_q;
  assign data  = data_q;
  assign last  = last_q;
  assign index = idx_q;
  assign err   = err_q;

endmodule

// File: tb/tb_zero_pattern_gen.sv
// Directed bench for zero_pattern_gen.
// Table of per-k runs plus hand sequences for err, restart and reset.
module tb_zero_pattern_gen;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] zeros;
  logic       busy;
  logic       valid;
  logic       ready;
  logic [7:0] data;
  logic       last;
  logic [6:0] index;
  logic       err;

  int checks   = 0;
  int failures = 0;

  zero_pattern_gen dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .zeros (zeros),
    .busy  (busy),
    .valid (valid),
    .ready (ready),
    .data  (data),
    .last  (last),
    .index (index),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int k;
    bit rnd;
    int count;
    int first;
    int lastv;
  } vec_t;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0d (0x%0h) expected=%0d (0x%0h)",
               name, act, act, expv, expv);
    end
  endtask

  function automatic int zc(input int v);
    int n;
    n = 0;
    for (int b = 0; b < 8; b++) if (((v >> b) & 1) == 0) n++;
    return n;
  endfunction

  // Smallest v >= from with k zero bits, or 256 if none.
  function automatic int next_w(input int from, input int k);
    for (int v = from; v < 256; v++) if (zc(v) == k) return v;
    return 256;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_enum(
    input  int k,
    input  bit rnd,
    input  int poke,
    input  int rst_at,
    output int beats,
    output int fst,
    output int lst
  );
    int  expv;
    int  cyc;
    bit  done;
    bit  poked;
    bit  r;
    beats = 0;
    fst   = -1;
    lst   = -1;
    done  = 0;
    poked = 0;
    cyc   = 0;
    expv  = next_w(0, k);
    start = 1'b1;
    zeros = k[3:0];
    step();
    start = 1'b0;
    chk("busy_on", busy, 1);
    while (!done && cyc < 400) begin
      cyc++;
      chk("valid", valid, 1);
      if (!valid) break;
      chk("data", data, expv);
      chk("index", index, beats);
      chk("zero_cnt", zc(data), k);
      chk("last", last, int'(next_w(expv + 1, k) == 256));
      chk("err_quiet", err, 0);
      if (beats == rst_at) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data", data, 0);
        chk("rst_index", index, 0);
        chk("rst_last", last, 0);
        return;
      end
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      ready = r;
      if (beats == poke && !poked) begin
        start = 1'b1;
        zeros = 4'd9;
        poked = 1;
      end
      step();
      start = 1'b0;
      zeros = k[3:0];
      if (r) begin
        if (beats == 0) fst = expv;
        lst = expv;
        beats++;
        expv = next_w(expv + 1, k);
        if (expv == 256) done = 1;
      end
    end
    chk("run_done", int'(done), 1);
    ready = 1'b0;
    chk("valid_off", valid, 0);
    chk("busy_off", busy, 0);
    chk("err_after", err, 0);
  endtask

  vec_t tbl[9];
  int   beats;
  int   fst;
  int   lst;
  int   badk[2];

  initial begin
    tbl[0] = '{0, 0, 1,  8'hFF, 8'hFF};
    tbl[1] = '{1, 0, 8,  8'h7F, 8'hFE};
    tbl[2] = '{2, 0, 28, 8'h3F, 8'hFC};
    tbl[3] = '{3, 0, 56, 8'h1F, 8'hF8};
    tbl[4] = '{4, 0, 70, 8'h0F, 8'hF0};
    tbl[5] = '{5, 0, 56, 8'h07, 8'hE0};
    tbl[6] = '{6, 1, 28, 8'h03, 8'hC0};
    tbl[7] = '{7, 0, 8,  8'h01, 8'h80};
    tbl[8] = '{8, 0, 1,  8'h00, 8'h00};
    badk[0] = 9;
    badk[1] = 15;

    reset = 1'b1;
    start = 1'b0;
    zeros = 4'd0;
    ready = 1'b0;
    repeat (3) step();
    chk("reset_busy", busy, 0);
    chk("reset_valid", valid, 0);
    chk("reset_data", data, 0);
    chk("reset_last", last, 0);
    chk("reset_index", index, 0);
    chk("reset_err", err, 0);
    reset = 1'b0;
    step();

    foreach (badk[i]) begin
      start = 1'b1;
      zeros = badk[i][3:0];
      step();
      start = 1'b0;
      chk("err_pulse", err, 1);
      chk("err_valid", valid, 0);
      chk("err_busy", busy, 0);
      step();
      chk("err_one_cycle", err, 0);
      chk("err_valid2", valid, 0);
    end

    foreach (tbl[i]) begin
      run_enum(tbl[i].k, tbl[i].rnd, -1, -1, beats, fst, lst);
      chk("tbl_count", beats, tbl[i].count);
      chk("tbl_first", fst, tbl[i].first);
      chk("tbl_lastv", lst, tbl[i].lastv);
      step();
    end

    // start mid-run is ignored; restart in the first IDLE cycle works.
    run_enum(2, 0, 10, -1, beats, fst, lst);
    chk("poke_count", beats, 28);
    run_enum(2, 0, -1, -1, beats, fst, lst);
    chk("b2b_count", beats, 28);
    chk("b2b_first", fst, 8'h3F);
    step();

    // start in the cycle of the final handshake is ignored.
    run_enum(1, 0, 7, -1, beats, fst, lst);
    chk("lastpoke_count", beats, 8);
    step();
    chk("lastpoke_idle", valid, 0);

    // reset mid-run, then a fresh k=1 enumeration.
    run_enum(4, 0, -1, 20, beats, fst, lst);
    chk("rst_beats", beats, 20);
    run_enum(1, 0, -1, -1, beats, fst, lst);
    chk("post_rst_count", beats, 8);
    chk("post_rst_first", fst, 8'h7F);
    chk("post_rst_last", lst, 8'hFE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/zero_pattern_gen.md
# zero_pattern_gen

Sequential inverse of the byte zero counter. Given a requested zero count k (0..8), the block enumerates every 8-bit value containing exactly k zero bits, in ascending numeric order. It emits one value per valid/ready handshake and flags the final value. It feeds stimulus and checking paths that need every byte of a given zero weight, for example exhaustive exercise of the zero counter.

## Interface
Parameters:
- None. Data width is fixed at 8 by a package constant.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin an enumeration; sampled only in IDLE.
- zeros  in  4  requested zero count k; sampled together with start.
- busy  out  1  high from the cycle after an accepted start until the cycle after the last handshake.
- valid  out  1  data/last/index are valid.
- ready  in  1  downstream accepts the current value when valid && ready.
- data  out  8  current pattern; holds exactly k zero bits.
- last  out  1  high with the final pattern of the enumeration.
- index  out  7  ordinal of the current pattern, starting at 0; maximum 69.
- err  out  1  one-cycle pulse when start arrives in IDLE with zeros > 8.

## Operation
- Reset values: busy=0, valid=0, data=0x00, last=0, index=0, err=0; state=IDLE.
- States and transitions:
  - IDLE: on start with zeros ≤ 8, load data with the smallest pattern, (1<<(8−k))−1, set index=0, go to EMIT. If k=8 the pattern is 0x00.
  - IDLE: on start with zeros > 8, pulse err for one cycle and stay in IDLE. No output.
  - EMIT: valid=1. If valid && !ready, data, last and index hold stable.
  - EMIT on handshake with last=0: data ← next larger byte with the same number of ones; index ← index+1.
  - EMIT on handshake with last=1: go to IDLE; valid=0 and busy=0 next cycle.
- last = (data == largest pattern). The largest pattern has its ones packed into the MSBs, which is ~((1<<k)−1) in 8 bits.
- Edge cases:
  - k=0 and k=8 each produce a single value (0xFF and 0x00 respectively), with last=1 on the first beat.
- Output count equals C(8,k): 1, 8, 28, 56, 70, 56, 28, 8, 1 for k = 0..8.
- Next-pattern arithmetic (same-popcount successor):
  - c = x & (−x); r = x + c; next = r | (((x ^ r) >> 2) >> ctz(c)).
  - All terms are 9 bits internally; the result is truncated to 8 bits.
  - Use a shift, not a divider.
- start during EMIT is ignored, with no err. There is no abort other than reset.
- reset mid-enumeration returns to IDLE next edge; every output takes its reset value.

## Timing
- Latency: start accepted at edge t → valid=1 with the first pattern after edge t, so it is visible in cycle t+1.
- Throughput: with ready held high, one new pattern per cycle. An enumeration takes C(8,k) cycles of valid.
- Back-to-back: start issued in the cycle the last handshake occurs is ignored, because state is still EMIT. The earliest accepted restart is the first IDLE cycle, which gives one dead cycle between enumerations.
- err asserts in the cycle after the offending start and lasts exactly one cycle.
- All outputs are registered; there is no combinational path from ready or start to any output.

## Structure
- Package zero_pattern_pkg holds:
  - DATA_W=8.
  - ZCNT_W=4.
  - IDX_W=7.
  - The state enum {IDLE, EMIT}.
- Sub-module next_same_weight: purely combinational 8-bit successor. It takes x and produces next; it contains the ctz encoder used by the successor arithmetic.
- The top level holds the FSM, data/index/last registers and err logic.

## Test plan
- k=4, ready always 1 → 70 beats. First 0x0F, second 0x17, third 0x1B; last 0xF0 with last=1 and index=69. Every beat has exactly 4 zeros, values are strictly ascending, and valid drops the next cycle.
- k=6 with ready toggled pseudo-randomly → 28 beats, 0x03, 0x05, 0x06, 0x09, … 0xC0. data and index are stable through every stall cycle, with no duplicates or skips.
- k=0 and k=8 → a single beat each: 0xFF and 0x00 respectively, both with last=1 and index=0.
- zeros=9 and zeros=15 in IDLE → a one-cycle err pulse each; valid and busy stay 0.
- start pulsed at beat 10 of a k=2 run → ignored, and the run completes with 28 beats. A new start one cycle after the final beat → a fresh run beginning 0x3F.
- reset asserted at index 20 of a k=4 run → next cycle valid=0, busy=0, data=0x00, index=0. A subsequent start with k=1 → 0x7F, 0xBF, … 0xFE, 8 beats.
